// File: rtl/surov_uart_mmio.sv
// surov_uart_mmio: memory-mapped 8N1 UART transmitter on the surov data bus.
// Sits next to the SRAM and uses the same registered-request timing.
// Register window (16 bytes at BASE_ADDR):
//   0x0 TXDATA (W)  push wdata[7:0] into the TX FIFO
//   0x4 STATUS      [0] full [1] empty [2] busy [3] overflow (W1C) [7:4] count
//   0x8 CTRL        [0] irq_en
//   0xC             reads 0
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_addr/rden/wren/size  core request, registered before decode
//   memwrite_data            LSB-aligned write data
//   rdata, hit               read data / window hit, valid the cycle after the request
//   tx                       serial line, idle high
//   irq                      irq_en & FIFO empty & serializer idle
module surov_uart_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_rden,
  input  logic        mem_wren,
  input  logic [2:0]  mem_size,
  input  logic [31:0] memwrite_data,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        tx,
  output logic        irq
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Byte/half extraction with sign or zero extension, SRAM load rules.
  function automatic logic [31:0] load_extend(input logic [31:0] w,
                                              input logic [1:0]  off,
                                              input logic [2:0]  sz);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return w;
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return 32'b0;
    endcase
  endfunction

  function automatic logic size_ok(input logic [2:0] sz);
    return (sz == 3'b000) || (sz == 3'b001) || (sz == 3'b010) ||
           (sz == 3'b100) || (sz == 3'b101);
  endfunction

  // Count field is only four bits wide; deep FIFOs report 15.
  function automatic logic [3:0] sat_count(input logic [CNT_W-1:0] c);
    if (32'(c) > 32'd15) return 4'hF;
    return 4'(c);
  endfunction

  logic [31:0] req_addr;
  logic        req_rden;
  logic        req_wren;
  logic [2:0]  req_size;
  logic [7:0]  req_wdata;
  logic        unused_wdata;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             irq_en;

  state_t            state;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;

  logic        full, empty, busy;
  logic        wr_en, wr_tx, wr_stat, wr_ctrl, push, pop;
  logic [1:0]  sel;
  logic [31:0] status_word;
  logic [31:0] reg_word;

  assign unused_wdata = ^memwrite_data[31:8];

  // Stage boundary: bus request -> registered request
  always_ff @(posedge clk) begin
    req_addr  <= mem_addr;
    req_size  <= mem_size;
    req_wdata <= memwrite_data[7:0];
    if (rst) begin
      req_rden <= 1'b0;
      req_wren <= 1'b0;
    end else begin
      req_rden <= mem_rden;
      req_wren <= mem_wren;
    end
  end

  assign hit     = (req_rden | req_wren) & (req_addr[31:4] == BASE_ADDR[31:4]);
  assign sel     = req_addr[3:2];
  assign wr_en   = hit & req_wren & size_ok(req_size);
  assign wr_tx   = wr_en & (sel == 2'd0);
  assign wr_stat = wr_en & (sel == 2'd1);
  assign wr_ctrl = wr_en & (sel == 2'd2);

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign busy  = (state != IDLE);
  assign irq   = irq_en & empty & ~busy;

  // A full FIFO drops the byte even if the serializer pops on the same edge.
  assign push = wr_tx & ~full;
  assign pop  = (state == IDLE) & ~empty;

  assign status_word = {24'b0, sat_count(count), overflow, busy, empty, full};

  always_comb begin
    reg_word = 32'b0;
    case (sel)
      2'd1:    reg_word = status_word;
      2'd2:    reg_word = {31'b0, irq_en};
      default: reg_word = 32'b0;
    endcase
  end

  // Reads see register state before any same-cycle write commits.
  assign rdata = (hit & req_rden) ? load_extend(reg_word, req_addr[1:0], req_size) : 32'b0;

  // Stage boundary: registered request -> FIFO / register commit
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= req_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      irq_en   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_tx & full)                overflow <= 1'b1;
      else if (wr_stat & req_wdata[3]) overflow <= 1'b0;
      if (wr_ctrl) irq_en <= req_wdata[0];
    end
  end

  // Stage boundary: FIFO head -> serial line
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= 3'd0;
      tx      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift <= fifo_mem[rd_ptr];
            baud  <= '0;
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (baud == BAUD_LAST) begin
            baud    <= '0;
            bit_idx <= 3'd0;
            state   <= DATA;
            tx      <= shift[0];
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            state <= IDLE;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_surov_uart_mmio.sv
// Directed bench for surov_uart_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_surov_uart_mmio;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_rden;
  logic        mem_wren;
  logic [2:0]  mem_size;
  logic [31:0] memwrite_data;
  logic [31:0] rdata;
  logic        hit;
  logic        tx;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  logic        h;
  logic [31:0] r;
  logic        bad;
  logic [9:0]  frame;
  logic [2:0]  sizes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  localparam logic [31:0] TXD  = 32'h1000_0000;
  localparam logic [31:0] STAT = 32'h1000_0004;
  localparam logic [31:0] CTRL = 32'h1000_0008;

  surov_uart_mmio #(
    .BASE_ADDR   (32'h1000_0000),
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr     (mem_addr),
    .mem_rden     (mem_rden),
    .mem_wren     (mem_wren),
    .mem_size     (mem_size),
    .memwrite_data(memwrite_data),
    .rdata        (rdata),
    .hit          (hit),
    .tx           (tx),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request for a cycle; return hit/rdata sampled in the decode cycle.
  task automatic req(input logic [31:0] a, input logic rd, input logic wr,
                     input logic [2:0] sz, input logic [31:0] d,
                     output logic ho, output logic [31:0] ro);
    @(negedge clk);
    mem_addr = a; mem_rden = rd; mem_wren = wr; mem_size = sz; memwrite_data = d;
    @(negedge clk);
    mem_rden = 1'b0; mem_wren = 1'b0;
    ho = hit; ro = rdata;
  endtask

  // Wait for a start bit, then sample each bit in its second cycle.
  task automatic recv_byte(input string tag, input logic [7:0] exp);
    logic [7:0] b;
    logic       seen;
    int         n;
    seen = 1'b0; n = 0; b = 8'h00;
    while (!seen && n < 200) begin
      @(negedge clk); n++;
      if (tx === 1'b0) seen = 1'b1;
    end
    check({tag, "_start"}, {31'b0, seen}, 32'd1);
    if (seen) begin
      repeat (5) @(negedge clk);
      b[0] = tx;
      for (int k = 1; k < 8; k++) begin
        repeat (4) @(negedge clk);
        b[k] = tx;
      end
      check({tag, "_byte"}, {24'b0, b}, {24'b0, exp});
      repeat (4) @(negedge clk);
      check({tag, "_stop"}, {31'b0, tx}, 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; mem_addr = 32'b0; mem_rden = 1'b0; mem_wren = 1'b0;
    mem_size = 3'b010; memwrite_data = 32'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_tx",    {31'b0, tx},  32'd1);
    check("rst_hit",   {31'b0, hit}, 32'd0);
    check("rst_rdata", rdata,        32'd0);
    check("rst_irq",   {31'b0, irq}, 32'd0);

    req(STAT, 1, 0, 3'b010, 0, h, r);
    check("stat_w_hit", {31'b0, h}, 32'd1);
    check("stat_w",     r,          32'h0000_0002);
    req(STAT, 1, 0, 3'b100, 0, h, r);
    check("stat_bu",    r,          32'h0000_0002);
    req(32'h2000_0004, 1, 0, 3'b010, 0, h, r);
    check("miss_hit",   {31'b0, h}, 32'd0);
    check("miss_rdata", r,          32'd0);
    req(32'h1000_000C, 1, 0, 3'b010, 0, h, r);
    check("off_c",      r,          32'd0);
    req(TXD, 1, 0, 3'b010, 0, h, r);
    check("off_0",      r,          32'd0);

    // 0xA5 frame: start, bits 1,0,1,0,0,1,0,1, stop, four cycles each.
    req(TXD, 0, 1, 3'b010, 32'h0000_00A5, h, r);
    check("a5_n1", {31'b0, tx}, 32'd1);
    @(negedge clk);
    check("a5_n2", {31'b0, tx}, 32'd1);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check($sformatf("a5_bit%0d_c%0d", i, c), {31'b0, tx}, {31'b0, frame[i]});
      end
    end
    @(negedge clk);
    check("a5_idle", {31'b0, tx}, 32'd1);

    // Burst of nine pushes while 0x5A occupies the serializer: 0x09 overflows.
    req(TXD, 0, 1, 3'b010, 32'h0000_005A, h, r);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      mem_addr = TXD + 32'(i % 4); mem_wren = 1'b1;
      mem_size = sizes[i % 5]; memwrite_data = 32'hDEAD_BE00 | 32'(i);
    end
    @(negedge clk);
    mem_wren = 1'b0;
    req(STAT, 1, 0, 3'b010, 0, h, r);
    check("burst_stat_w",  r, 32'h0000_008D);
    req(STAT, 1, 0, 3'b000, 0, h, r);
    check("burst_stat_b",  r, 32'hFFFF_FF8D);
    req(STAT, 1, 0, 3'b100, 0, h, r);
    check("burst_stat_bu", r, 32'h0000_008D);
    req(STAT, 1, 0, 3'b001, 0, h, r);
    check("burst_stat_h",  r, 32'h0000_008D);
    req(32'h1000_0005, 1, 0, 3'b000, 0, h, r);
    check("burst_stat_b1", r, 32'h0000_0000);
    req(STAT, 1, 0, 3'b011, 0, h, r);
    check("bad_size_hit",  {31'b0, h}, 32'd1);
    check("bad_size_rd",   r, 32'h0000_0000);
    repeat (18) @(negedge clk);
    check("5a_stop", {31'b0, tx}, 32'd1);
    for (int i = 1; i <= 8; i++) recv_byte($sformatf("burst%0d", i), 8'(i));
    bad = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) bad = 1'b1;
    end
    check("no_byte9", {31'b0, bad}, 32'd0);

    // Overflow stays sticky until a STATUS write with bit3 set.
    req(STAT, 1, 0, 3'b010, 0, h, r);
    check("ovf_sticky", r, 32'h0000_000A);
    req(STAT, 0, 1, 3'b010, 32'hFFFF_FFF7, h, r);
    req(STAT, 1, 0, 3'b010, 0, h, r);
    check("ovf_no_clr", r, 32'h0000_000A);
    req(STAT, 0, 1, 3'b010, 32'h0000_0008, h, r);
    req(STAT, 1, 0, 3'b010, 0, h, r);
    check("ovf_clr", r, 32'h0000_0002);
    req(STAT, 0, 1, 3'b001, 32'h0000_FFFF, h, r);
    req(STAT, 1, 0, 3'b010, 0, h, r);
    check("stat_h_wr", r, 32'h0000_0002);

    // irq: enable with simultaneous read, then one frame of 0x55.
    req(CTRL, 1, 1, 3'b010, 32'h0000_0001, h, r);
    check("ctrl_rw_old", r, 32'd0);
    @(negedge clk);
    check("irq_on", {31'b0, irq}, 32'd1);
    req(CTRL, 1, 0, 3'b000, 0, h, r);
    check("ctrl_rd", r, 32'd1);
    req(TXD, 0, 1, 3'b010, 32'h0000_0055, h, r);
    check("irq_pre_push", {31'b0, irq}, 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 41; i++) begin
      @(negedge clk);
      if (irq !== 1'b0) bad = 1'b1;
    end
    check("irq_low_frame", {31'b0, bad}, 32'd0);
    @(negedge clk);
    check("irq_after_stop", {31'b0, irq}, 32'd1);
    req(32'h1000_000B, 0, 1, 3'b000, 32'h0000_00FE, h, r);
    @(negedge clk);
    check("irq_off", {31'b0, irq}, 32'd0);

    // Reset mid-DATA with a second byte queued and a CTRL write pending.
    req(TXD, 0, 1, 3'b010, 32'h0000_0000, h, r);
    req(TXD, 0, 1, 3'b010, 32'h0000_00FF, h, r);
    repeat (6) @(negedge clk);
    check("mid_data_low", {31'b0, tx}, 32'd0);
    @(negedge clk);
    mem_addr = CTRL; mem_wren = 1'b1; mem_size = 3'b010; memwrite_data = 32'h1;
    @(negedge clk);
    mem_wren = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_tx",  {31'b0, tx},  32'd1);
    check("rst_mid_irq", {31'b0, irq}, 32'd0);
    req(CTRL, 1, 0, 3'b010, 0, h, r);
    check("rst_mid_ctrl", r, 32'd0);
    req(STAT, 1, 0, 3'b010, 0, h, r);
    check("rst_mid_stat", r, 32'h0000_0002);
    bad = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) bad = 1'b1;
    end
    check("rst_no_frame", {31'b0, bad}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
